// File: rtl/mem_burst_responder.sv
// mem_burst_responder
// Responder end of the cache burst interface on the sys_clk domain. It takes
// one read or write request at a time, streams or absorbs a fixed-length burst
// against an internal word array, and wraps at the top of that array. Every
// output comes straight from a register, so no input reaches an output
// combinationally. The word array is never reset and keeps its contents
// across sys_rst_n.

module mem_burst_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int NUM_WORDS       = 128,
    parameter int READ_BURST_LEN  = 8,
    parameter int WRITE_BURST_LEN = 8,
    parameter int READ_LATENCY    = 2
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,

    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [DATA_ADDR_WIDTH-1:0] req_addr,

    input  logic                       wdata_valid,
    output logic                       wdata_ready,
    input  logic [DATA_WIDTH-1:0]      wdata,

    output logic                       rdata_valid,
    input  logic                       rdata_ready,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       rdata_last,

    output logic                       wresp_valid,
    input  logic                       wresp_ready
);

    // Word index width; the array is a power of two deep, so the address
    // counter wraps at the top of memory simply by overflowing.
    localparam int WORD_AW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    // The beat counter is shared by both burst directions, so it is sized for
    // the longer one, with a spare bit so the final index always fits.
    localparam int MAX_BURST = (READ_BURST_LEN > WRITE_BURST_LEN) ? READ_BURST_LEN
                                                                 : WRITE_BURST_LEN;
    localparam int BEAT_CW   = $clog2(MAX_BURST) + 1;

    // The latency counter must hold READ_LATENCY itself; keep it one bit wide
    // when there is no latency so the declaration stays legal.
    localparam int LAT_CW    = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

    localparam logic [BEAT_CW-1:0] RD_LAST_BEAT   = BEAT_CW'(READ_BURST_LEN - 1);
    localparam logic [BEAT_CW-1:0] WR_LAST_BEAT   = BEAT_CW'(WRITE_BURST_LEN - 1);
    localparam logic [LAT_CW-1:0]  LAT_INIT       = LAT_CW'(READ_LATENCY);
    localparam logic [LAT_CW-1:0]  LAT_ONE        = LAT_CW'(1);
    localparam logic               RD_SINGLE_BEAT = (READ_BURST_LEN == 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_RESP
    } state_t;

    state_t               state;
    logic [BEAT_CW-1:0]   beat_cnt;
    logic [LAT_CW-1:0]    lat_cnt;
    logic [WORD_AW-1:0]   addr_cnt;

    logic [WORD_AW-1:0]   start_index;
    logic [WORD_AW-1:0]   next_addr;
    logic [BEAT_CW-1:0]   next_beat;
    logic                 req_fire;
    logic                 rd_fire;
    logic                 wr_fire;

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    // Only the word-index bits of the request address are meaningful; the
    // byte-lane bits and everything above the array size are ignored.
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^req_addr;

    assign start_index = req_addr[2 +: WORD_AW];
    assign next_addr   = addr_cnt + WORD_AW'(1);
    assign next_beat   = beat_cnt + BEAT_CW'(1);

    assign req_fire    = req_valid && req_ready;
    assign rd_fire     = rdata_valid && rdata_ready;

    // A write beat lands only on a real handshake and never on an edge where
    // reset is asserted, so an aborted burst keeps just the beats already taken.
    assign wr_fire     = sys_rst_n && (state == WR_BURST) && wdata_valid && wdata_ready;

    // Backing store: one word per accepted write beat, contents survive reset.
    always_ff @(posedge sys_clk) begin
        if (wr_fire) begin
            mem[addr_cnt] <= wdata;
        end
    end

    // Burst sequencer: state, counters and every registered output.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            lat_cnt     <= '0;
            addr_cnt    <= '0;
            req_ready   <= 1'b0;
            wdata_ready <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            rdata_last  <= 1'b0;
            wresp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_fire) begin
                        req_ready <= 1'b0;
                        addr_cnt  <= start_index;
                        beat_cnt  <= '0;
                        if (req_write) begin
                            state       <= WR_BURST;
                            wdata_ready <= 1'b1;
                        end else if (READ_LATENCY == 0) begin
                            state       <= RD_BURST;
                            rdata_valid <= 1'b1;
                            rdata       <= mem[start_index];
                            rdata_last  <= RD_SINGLE_BEAT;
                        end else begin
                            state   <= RD_WAIT;
                            lat_cnt <= LAT_INIT;
                        end
                    end
                end

                RD_WAIT: begin
                    lat_cnt <= lat_cnt - LAT_ONE;
                    if (lat_cnt == LAT_ONE) begin
                        state       <= RD_BURST;
                        rdata_valid <= 1'b1;
                        rdata       <= mem[addr_cnt];
                        rdata_last  <= RD_SINGLE_BEAT;
                    end
                end

                RD_BURST: begin
                    if (rd_fire) begin
                        if (rdata_last) begin
                            state       <= IDLE;
                            rdata_valid <= 1'b0;
                            rdata_last  <= 1'b0;
                            beat_cnt    <= '0;
                            req_ready   <= 1'b1;
                        end else begin
                            beat_cnt   <= next_beat;
                            addr_cnt   <= next_addr;
                            rdata      <= mem[next_addr];
                            rdata_last <= (next_beat == RD_LAST_BEAT);
                        end
                    end
                end

                WR_BURST: begin
                    if (wdata_valid) begin
                        addr_cnt <= next_addr;
                        if (beat_cnt == WR_LAST_BEAT) begin
                            state       <= WR_RESP;
                            wdata_ready <= 1'b0;
                            wresp_valid <= 1'b1;
                            beat_cnt    <= '0;
                        end else begin
                            beat_cnt <= next_beat;
                        end
                    end
                end

                WR_RESP: begin
                    if (wresp_ready) begin
                        state       <= IDLE;
                        wresp_valid <= 1'b0;
                        req_ready   <= 1'b1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    req_ready   <= 1'b0;
                    wdata_ready <= 1'b0;
                    rdata_valid <= 1'b0;
                    rdata_last  <= 1'b0;
                    wresp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_burst_responder.md
# mem_burst_responder

Single-clock burst memory target that answers the line-fill and write-back bursts issued by the chip's instruction/data caches on the `sys_clk` domain. It accepts one request at a time (read or write), streams `READ_BURST_LEN` beats out or absorbs `WRITE_BURST_LEN` beats in, and backs them with an internal word array. It sits on the `sys_clk` side of the chip as the responder end of the cache burst interface and replaces the behavioural memory model in chip-level simulation.

## Interface

- `DATA_WIDTH`, 32, beat and memory word width in bits
- `DATA_ADDR_WIDTH`, 32, request byte-address width
- `NUM_WORDS`, 128, memory depth in words; power of two
- `READ_BURST_LEN`, 8, beats per read burst; ≥1
- `WRITE_BURST_LEN`, 8, beats per write burst; ≥1
- `READ_LATENCY`, 2, idle cycles between read request acceptance and the first beat; ≥0

Ports:

- `sys_clk`  in  1  clock
- `sys_rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder idle, can accept a request
- `req_write`  in  1  1 = write burst, 0 = read burst
- `req_addr`  in  DATA_ADDR_WIDTH  start byte address
- `wdata_valid`  in  1  write beat present
- `wdata_ready`  out  1  responder accepting write beats
- `wdata`  in  DATA_WIDTH  write beat
- `rdata_valid`  out  1  read beat present
- `rdata_ready`  in  1  initiator accepting read beat
- `rdata`  out  DATA_WIDTH  read beat
- `rdata_last`  out  1  final beat of read burst, qualified by `rdata_valid`
- `wresp_valid`  out  1  write burst committed
- `wresp_ready`  in  1  initiator accepts write response

## Operation

- FSM states: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_RESP.
- The request handshake is `req_valid && req_ready`. `req_ready` is high only in IDLE. Requests are not queued. `req_valid` outside IDLE is ignored.
- Start word index is `req_addr[2 +: log2(NUM_WORDS)]`. Bits [1:0] and the upper bits are ignored. Bursts are not aligned. Beat k uses word `(start + k) mod NUM_WORDS`, so bursts wrap at the top of memory.
- Read path:
  - On acceptance, go to RD_WAIT with the latency counter set to `READ_LATENCY`. If `READ_LATENCY` = 0, go directly to RD_BURST.
  - RD_WAIT decrements the counter each cycle and moves to RD_BURST after `READ_LATENCY` cycles.
  - In RD_BURST, `rdata_valid` = 1. Beat index and address advance only on `rdata_valid && rdata_ready`.
  - `rdata` and `rdata_last` hold stable while stalled.
  - `rdata_last` = 1 on beat `READ_BURST_LEN-1`. Its handshake returns the FSM to IDLE.
- Write path:
  - On acceptance, go to WR_BURST, where `wdata_ready` = 1.
  - Each `wdata_valid && wdata_ready` writes `wdata` to the current word and advances. Gaps in `wdata_valid` are allowed.
  - After beat `WRITE_BURST_LEN-1`, go to WR_RESP, where `wresp_valid` = 1 until `wresp_valid && wresp_ready`, then IDLE.
- Write data is visible to any read request accepted after the `wresp` handshake.
- Memory contents are not reset and persist across `sys_rst_n`. The test bench preloads them hierarchically.
- Reset, including mid-burst:
  - Next state is IDLE; beat and latency counters clear.
  - All outputs are 0, including `req_ready`, `rdata`, `rdata_last`, `wdata_ready`, and `wresp_valid`.
  - A partially written burst keeps the beats already written. The remaining beats are never written.

## Timing

- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- `req_ready` rises on the first edge with `sys_rst_n` = 1, so it is 1 in the cycle after reset deasserts.
- Read with the request handshake at edge T: the first `rdata_valid` appears in cycle T+1+`READ_LATENCY`. With no backpressure, beats are contiguous and the last beat is in cycle T+`READ_LATENCY`+`READ_BURST_LEN`.
- Write with the request handshake at edge T: `wdata_ready` = 1 from cycle T+1. With `wdata_valid` held high, `wresp_valid` = 1 in cycle T+1+`WRITE_BURST_LEN`.
- Last read beat or `wresp` handshake at edge E: `req_ready` = 1 in cycle E+1. The minimum gap between bursts is one idle cycle.
- Beat counter width is `$clog2(max(READ_BURST_LEN, WRITE_BURST_LEN))+1`. The address counter wraps naturally at `log2(NUM_WORDS)` bits.

## Test plan

- **Write then read:** write burst at `req_addr`=0x40 with beats 0x100..0x107, then read 0x40 with `READ_LATENCY`=2 → `wresp_valid` in cycle T+9; the read returns 0x100..0x107, first `rdata_valid` 3 cycles after the request handshake, `rdata_last` only on 0x107.
- **Wrap-around:** write burst at 0x1F0 (word 124) with 0xA0..0xA7, then read 0x1F0 → words 124..127 and 0..3 hold 0xA0..0xA7; the read returns the same sequence.
- **Read backpressure:** toggle `rdata_ready` 1,0,0,1,… during a read of preloaded words → each beat is held stable while `rdata_ready` = 0; exactly 8 handshakes in order; no beat dropped or duplicated.
- **Write gaps and response stall:**
  - Drive `wdata_valid` low for 3 cycles between beats 3 and 4 → only handshaked beats are written.
  - Hold `wresp_ready` = 0 for 5 cycles → `wresp_valid` stays 1 and `req_ready` stays 0 until the `wresp` handshake.
- **Busy and back-to-back:** hold `req_valid` = 1 continuously with alternating read and write requests → each is accepted only in IDLE, one idle cycle between bursts, no request lost or duplicated.
- **Reset mid-burst:** assert `sys_rst_n` = 0 for one cycle after write beat 3 → all outputs are 0 next cycle, `req_ready` = 1 the cycle after release, words for beats 0..3 updated, words for beats 4..7 unchanged.
